// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register bank.
// Optional lookup ports exist only when REG_WR_BYPASS_EN is defined.
interface reg_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Valid/ready: a write transfers on the rising edge where X_VALID & X_READY;
    // X_READY comes only from registered state and never looks at X_VALID.
    logic                     A_VALID;
    logic                     A_READY;
    logic [ADDR_W-1:0]        A_ADDR;
    logic [DATA_W-1:0]        A_DATA;
    logic                     B_VALID;
    logic                     B_READY;
    logic [ADDR_W-1:0]        B_ADDR;
    logic [DATA_W-1:0]        B_DATA;
    logic                     REG_WRITE;
    logic [ADDR_W-1:0]        WRITE_REGISTER;
    logic [DATA_W-1:0]        WRITE_DATA;
    logic [(1<<ADDR_W)-1:0]   PENDING;
    logic                     BUSY;
`ifdef REG_WR_BYPASS_EN
    logic [ADDR_W-1:0]        Q1_ADDR;
    logic [ADDR_W-1:0]        Q2_ADDR;
    logic                     Q1_HIT;
    logic                     Q2_HIT;
    logic [DATA_W-1:0]        Q1_DATA;
    logic [DATA_W-1:0]        Q2_DATA;

    modport master (
        output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, Q1_ADDR, Q2_ADDR,
        input  A_READY, B_READY, REG_WRITE, WRITE_REGISTER, WRITE_DATA, PENDING, BUSY,
        input  Q1_HIT, Q2_HIT, Q1_DATA, Q2_DATA
    );
    modport slave (
        input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, Q1_ADDR, Q2_ADDR,
        output A_READY, B_READY, REG_WRITE, WRITE_REGISTER, WRITE_DATA, PENDING, BUSY,
        output Q1_HIT, Q2_HIT, Q1_DATA, Q2_DATA
    );
`else
    modport master (
        output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
        input  A_READY, B_READY, REG_WRITE, WRITE_REGISTER, WRITE_DATA, PENDING, BUSY
    );
    modport slave (
        input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
        output A_READY, B_READY, REG_WRITE, WRITE_REGISTER, WRITE_DATA, PENDING, BUSY
    );
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU (A) and load (B)
// writeback, with same-register age ordering. Define REG_WR_BYPASS_EN for the lookup ports.
module reg_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic               CLK,
    input logic               RST_N,
    reg_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic              full_a, full_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              rr_b;
    logic              a_older;

    logic              grant_a, grant_b, both_full, same_addr;
    logic              ready_a, ready_b, acc_a, acc_b, kept_a, kept_b;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    logic              reg_write_q;
    logic [ADDR_W-1:0] wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [NREG-1:0]   pending;

    // Same-register conflicts must retire in age order, so age beats the pointer there.
    always_comb begin
        both_full = full_a & full_b;
        same_addr = (addr_a == addr_b);
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (both_full) begin
            grant_a = same_addr ? a_older : ~rr_b;
            grant_b = ~grant_a;
        end else begin
            grant_a = full_a;
            grant_b = full_b;
        end
    end

    assign ready_a  = ~full_a | grant_a;
    assign ready_b  = ~full_b | grant_b;
    assign acc_a    = bus.A_VALID & ready_a;
    assign acc_b    = bus.B_VALID & ready_b;
    assign kept_a   = full_a & ~grant_a;
    assign kept_b   = full_b & ~grant_b;
    assign gnt_addr = grant_b ? addr_b : addr_a;
    assign gnt_data = grant_b ? data_b : data_a;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full_a      <= 1'b0;
            full_b      <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            data_a      <= '0;
            data_b      <= '0;
            rr_b        <= 1'b0;
            a_older     <= 1'b0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            full_a <= acc_a | kept_a;
            full_b <= acc_b | kept_b;
            if (acc_a) begin
                addr_a <= bus.A_ADDR;
                data_a <= bus.A_DATA;
            end
            if (acc_b) begin
                addr_b <= bus.B_ADDR;
                data_b <= bus.B_DATA;
            end
            if (both_full && !same_addr)
                rr_b <= grant_a;
            // An entry already sitting in a buffer is older than one arriving now.
            if (acc_a && acc_b)
                a_older <= 1'b1;
            else if (acc_a && kept_b)
                a_older <= 1'b0;
            else if (acc_b && kept_a)
                a_older <= 1'b1;
            // Register 0 drains silently: no strobe toward the bank.
            reg_write_q <= (grant_a | grant_b) & (gnt_addr != '0);
            if (grant_a || grant_b) begin
                wr_reg_q  <= gnt_addr;
                wr_data_q <= gnt_data;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (full_a)      pending[addr_a]   = 1'b1;
        if (full_b)      pending[addr_b]   = 1'b1;
        if (reg_write_q) pending[wr_reg_q] = 1'b1;
        pending[0] = 1'b0;
    end

    assign bus.A_READY        = ready_a;
    assign bus.B_READY        = ready_b;
    assign bus.REG_WRITE      = reg_write_q;
    assign bus.WRITE_REGISTER = wr_reg_q;
    assign bus.WRITE_DATA     = wr_data_q;
    assign bus.PENDING        = pending;
    assign bus.BUSY           = full_a | full_b | reg_write_q;

`ifdef REG_WR_BYPASS_EN
    logic              y_full, o_full;
    logic [ADDR_W-1:0] y_addr, o_addr;
    logic [DATA_W-1:0] y_data, o_data;
    logic [ADDR_W-1:0] q_addr [2];
    logic              q_hit  [2];
    logic [DATA_W-1:0] q_data [2];

    assign q_addr[0] = bus.Q1_ADDR;
    assign q_addr[1] = bus.Q2_ADDR;

    // Youngest value wins: younger buffer, then older buffer, then the output register.
    always_comb begin
        y_full = a_older ? full_b : full_a;
        y_addr = a_older ? addr_b : addr_a;
        y_data = a_older ? data_b : data_a;
        o_full = a_older ? full_a : full_b;
        o_addr = a_older ? addr_a : addr_b;
        o_data = a_older ? data_a : data_b;
        for (int i = 0; i < 2; i++) begin
            q_hit[i]  = 1'b0;
            q_data[i] = '0;
            if (q_addr[i] != '0) begin
                if (y_full && y_addr == q_addr[i]) begin
                    q_hit[i]  = 1'b1;
                    q_data[i] = y_data;
                end else if (o_full && o_addr == q_addr[i]) begin
                    q_hit[i]  = 1'b1;
                    q_data[i] = o_data;
                end else if (reg_write_q && wr_reg_q == q_addr[i]) begin
                    q_hit[i]  = 1'b1;
                    q_data[i] = wr_data_q;
                end
            end
        end
    end

    assign bus.Q1_HIT  = q_hit[0];
    assign bus.Q2_HIT  = q_hit[1];
    assign bus.Q1_DATA = q_data[0];
    assign bus.Q2_DATA = q_data[1];
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: handshake, round-robin, age ordering, r0, async reset
// and (with REG_WR_BYPASS_EN) the lookup ports.
module tb_reg_write_arbiter;
  logic CLK;
  logic RST_N;
  int   tests_run    = 0;
  int   tests_failed = 0;

  reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.A_VALID = 1'b0;
    bus.A_ADDR  = '0;
    bus.A_DATA  = '0;
    bus.B_VALID = 1'b0;
    bus.B_ADDR  = '0;
    bus.B_DATA  = '0;
`ifdef REG_WR_BYPASS_EN
    bus.Q1_ADDR = '0;
    bus.Q2_ADDR = '0;
`endif
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL reset_reg_write: got %0b want 0", bus.REG_WRITE); end
    tests_run++; if (bus.WRITE_REGISTER !== 5'd0) begin tests_failed++; $display("FAIL reset_write_register: got %0d want 0", bus.WRITE_REGISTER); end
    tests_run++; if (bus.WRITE_DATA !== 32'h0) begin tests_failed++; $display("FAIL reset_write_data: got %h want 0", bus.WRITE_DATA); end
    tests_run++; if (bus.PENDING !== 32'h0) begin tests_failed++; $display("FAIL reset_pending: got %h want 0", bus.PENDING); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.BUSY); end
    tests_run++; if ({bus.A_READY, bus.B_READY} !== 2'b11) begin tests_failed++; $display("FAIL reset_ready: got %b want 11", {bus.A_READY, bus.B_READY}); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd5; bus.A_DATA = 32'h0000_00AA;
    tests_run++; if (bus.A_READY !== 1'b1) begin tests_failed++; $display("FAIL single_a_ready: got %0b want 1", bus.A_READY); end
    tick();
    bus.A_VALID = 1'b0;
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL single_no_early_strobe: got %0b want 0", bus.REG_WRITE); end
    tests_run++; if (bus.PENDING !== 32'h0000_0020) begin tests_failed++; $display("FAIL single_pending_c1: got %h want 00000020", bus.PENDING); end
    tick();
    tests_run++; if (bus.REG_WRITE !== 1'b1) begin tests_failed++; $display("FAIL single_strobe: got %0b want 1", bus.REG_WRITE); end
    tests_run++; if (bus.WRITE_REGISTER !== 5'd5) begin tests_failed++; $display("FAIL single_write_register: got %0d want 5", bus.WRITE_REGISTER); end
    tests_run++; if (bus.WRITE_DATA !== 32'h0000_00AA) begin tests_failed++; $display("FAIL single_write_data: got %h want 000000aa", bus.WRITE_DATA); end
    tests_run++; if (bus.PENDING !== 32'h0000_0020) begin tests_failed++; $display("FAIL single_pending_c2: got %h want 00000020", bus.PENDING); end
    tick();
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL single_strobe_one_cycle: got %0b want 0", bus.REG_WRITE); end
    tests_run++; if (bus.PENDING !== 32'h0) begin tests_failed++; $display("FAIL single_pending_clear: got %h want 0", bus.PENDING); end
    tests_run++; if (bus.WRITE_REGISTER !== 5'd5) begin tests_failed++; $display("FAIL single_register_hold: got %0d want 5", bus.WRITE_REGISTER); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL single_busy_clear: got %0b want 0", bus.BUSY); end
  endtask

  task automatic test_round_robin();
    logic [36:0] exp_q[$];
    logic [36:0] got;
    int a_cnt = 0;
    int b_cnt = 0;
    logic acc_a, acc_b;
    // Both accept at the first edge, then strobes alternate A,B,... from the next edge.
    for (int k = 0; k < 9; k++)
      exp_q.push_back((k % 2 == 0) ? {5'd3, 32'hA0 + 32'(k / 2)} : {5'd7, 32'hB0 + 32'(k / 2)});
    for (int i = 0; i < 12; i++) begin
      bus.A_VALID = (i < 8); bus.A_ADDR = 5'd3; bus.A_DATA = 32'hA0 + 32'(a_cnt);
      bus.B_VALID = (i < 8); bus.B_ADDR = 5'd7; bus.B_DATA = 32'hB0 + 32'(b_cnt);
      if (i < 8) begin
        tests_run++; if ((bus.A_READY | bus.B_READY) !== 1'b1) begin tests_failed++; $display("FAIL rr_ready_stall: cycle %0d A_READY %0b B_READY %0b", i, bus.A_READY, bus.B_READY); end
      end
      acc_a = bus.A_VALID & bus.A_READY;
      acc_b = bus.B_VALID & bus.B_READY;
      tick();
      if (acc_a) a_cnt++;
      if (acc_b) b_cnt++;
      tests_run++; if (bus.REG_WRITE !== (i >= 1 && i <= 9)) begin tests_failed++; $display("FAIL rr_strobe_rate: cycle %0d got %0b want %0b", i, bus.REG_WRITE, (i >= 1 && i <= 9)); end
      if (bus.REG_WRITE === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rr_extra_strobe: cycle %0d got r%0d=%h want none", i, bus.WRITE_REGISTER, bus.WRITE_DATA);
        end else begin
          got = exp_q.pop_front();
          if ({bus.WRITE_REGISTER, bus.WRITE_DATA} !== got) begin tests_failed++; $display("FAIL rr_order: cycle %0d got r%0d=%h want r%0d=%h", i, bus.WRITE_REGISTER, bus.WRITE_DATA, got[36:32], got[31:0]); end
        end
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rr_missing: got %0d strobes short want 0", exp_q.size()); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL rr_busy_end: got %0b want 0", bus.BUSY); end
    idle_inputs();
  endtask

  task automatic test_same_reg();
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd9; bus.A_DATA = 32'h11;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd9; bus.B_DATA = 32'h22;
    tick();
    tests_run++; if (bus.PENDING !== 32'h0000_0200) begin tests_failed++; $display("FAIL same_pending: got %h want 00000200", bus.PENDING); end
    // A is older (simultaneous load) so it drains and can reload r9 the same edge.
    bus.A_DATA = 32'h33; bus.B_VALID = 1'b0;
    tests_run++; if ({bus.A_READY, bus.B_READY} !== 2'b10) begin tests_failed++; $display("FAIL same_ready: got %b want 10", {bus.A_READY, bus.B_READY}); end
    tick();
    bus.A_VALID = 1'b0;
    tests_run++; if ({bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h11}) begin tests_failed++; $display("FAIL same_first: got %0b r%0d=%h want 1 r9=11", bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA); end
    tick();
    tests_run++; if ({bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h22}) begin tests_failed++; $display("FAIL same_second: got %0b r%0d=%h want 1 r9=22", bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA); end
    tick();
    tests_run++; if ({bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h33}) begin tests_failed++; $display("FAIL same_third: got %0b r%0d=%h want 1 r9=33", bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA); end
    tick();
    tests_run++; if (bus.PENDING[9] !== 1'b0) begin tests_failed++; $display("FAIL same_pending_clear: got %0b want 0", bus.PENDING[9]); end
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL same_strobe_end: got %0b want 0", bus.REG_WRITE); end
    idle_inputs();
  endtask

  task automatic test_reg_zero();
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd0; bus.B_DATA = 32'hFFFF_FFFF;
    tick();
    bus.B_VALID = 1'b0;
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL r0_busy: got %0b want 1", bus.BUSY); end
    tests_run++; if (bus.PENDING !== 32'h0) begin tests_failed++; $display("FAIL r0_pending_c1: got %h want 0", bus.PENDING); end
    tick();
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL r0_no_strobe: got %0b want 0", bus.REG_WRITE); end
    tests_run++; if (bus.PENDING !== 32'h0) begin tests_failed++; $display("FAIL r0_pending_c2: got %h want 0", bus.PENDING); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL r0_drained: got %0b want 0", bus.BUSY); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.A_VALID = (i < 3); bus.A_ADDR = 5'd6; bus.A_DATA = 32'h61 + 32'(i);
      if (i < 3) begin
        tests_run++; if (bus.A_READY !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: cycle %0d got %0b want 1", i, bus.A_READY); end
      end
      tick();
      if (i >= 1 && i <= 3) begin
        tests_run++; if ({bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA} !== {1'b1, 5'd6, 32'h60 + 32'(i)}) begin tests_failed++; $display("FAIL b2b_order: cycle %0d got %0b r%0d=%h want 1 r6=%h", i, bus.REG_WRITE, bus.WRITE_REGISTER, bus.WRITE_DATA, 32'h60 + 32'(i)); end
      end else begin
        tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: cycle %0d got %0b want 0", i, bus.REG_WRITE); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd10; bus.A_DATA = 32'hA10;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd11; bus.B_DATA = 32'hB11;
    tick();
    bus.A_ADDR = 5'd12; bus.A_DATA = 32'hA12; bus.B_VALID = 1'b0;
    tick();
    bus.A_VALID = 1'b0;
    tests_run++; if ({bus.REG_WRITE, bus.PENDING} !== {1'b1, 32'h0000_1C00}) begin tests_failed++; $display("FAIL arst_setup: got %0b %h want 1 00001c00", bus.REG_WRITE, bus.PENDING); end
    #3 RST_N = 1'b0;
    #1;
    tests_run++; if (bus.REG_WRITE !== 1'b0) begin tests_failed++; $display("FAIL arst_reg_write: got %0b want 0", bus.REG_WRITE); end
    tests_run++; if (bus.PENDING !== 32'h0) begin tests_failed++; $display("FAIL arst_pending: got %h want 0", bus.PENDING); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %0b want 0", bus.BUSY); end
    @(posedge CLK);
    #3 RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({bus.REG_WRITE, bus.BUSY} !== 2'b00) begin tests_failed++; $display("FAIL arst_stale: cycle %0d got REG_WRITE %0b BUSY %0b want 0 0", i, bus.REG_WRITE, bus.BUSY); end
    end
  endtask

`ifdef REG_WR_BYPASS_EN
  task automatic test_bypass();
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd4; bus.A_DATA = 32'h10;
    tick();
    bus.A_VALID = 1'b0;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd4; bus.B_DATA = 32'h20;
    bus.Q1_ADDR = 5'd4; bus.Q2_ADDR = 5'd0;
    #1;
    tests_run++; if ({bus.Q1_HIT, bus.Q1_DATA} !== {1'b1, 32'h10}) begin tests_failed++; $display("FAIL byp_a_buffer: got %0b %h want 1 00000010", bus.Q1_HIT, bus.Q1_DATA); end
    tick();
    bus.B_VALID = 1'b0;
    tests_run++; if ({bus.Q1_HIT, bus.Q1_DATA} !== {1'b1, 32'h20}) begin tests_failed++; $display("FAIL byp_youngest: got %0b %h want 1 00000020", bus.Q1_HIT, bus.Q1_DATA); end
    tests_run++; if ({bus.Q2_HIT, bus.Q2_DATA} !== {1'b0, 32'h0}) begin tests_failed++; $display("FAIL byp_r0: got %0b %h want 0 00000000", bus.Q2_HIT, bus.Q2_DATA); end
    tick();
    tests_run++; if ({bus.Q1_HIT, bus.Q1_DATA} !== {1'b1, 32'h20}) begin tests_failed++; $display("FAIL byp_output_reg: got %0b %h want 1 00000020", bus.Q1_HIT, bus.Q1_DATA); end
    tick();
    tests_run++; if ({bus.Q1_HIT, bus.Q1_DATA} !== {1'b0, 32'h0}) begin tests_failed++; $display("FAIL byp_retired: got %0b %h want 0 00000000", bus.Q1_HIT, bus.Q1_DATA); end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_reg();
    test_reg_zero();
    test_back_to_back();
    test_async_reset();
`ifdef REG_WR_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of the 32x32 register bank (REGISTRO: REG_WRITE / WRITE_REGISTER / WRITE_DATA) between two writeback sources: requester A (ALU result) and requester B (memory load data).
- Each requester has a 1-entry holding buffer with a valid/ready handshake.
- Arbitration is round-robin, with a same-register ordering override.
- Exports a pending-write scoreboard that the hazard unit uses to stall dependent reads.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width; the bank has 2**ADDR_W registers.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- A_VALID  input  1  requester A presents a write.
- A_READY  output  1  A buffer can accept this cycle.
- A_ADDR  input  ADDR_W  target register for A.
- A_DATA  input  DATA_W  write data for A.
- B_VALID  input  1  requester B presents a write.
- B_READY  output  1  B buffer can accept this cycle.
- B_ADDR  input  ADDR_W  target register for B.
- B_DATA  input  DATA_W  write data for B.
- REG_WRITE  output  1  write strobe to the register bank.
- WRITE_REGISTER  output  ADDR_W  write index to the register bank.
- WRITE_DATA  output  DATA_W  write data to the register bank.
- PENDING  output  2**ADDR_W  one bit per register with an accepted but not yet retired write.
- BUSY  output  1  any buffer full or REG_WRITE high.

Behaviour:
- Reset (async, RST_N=0):
  - Both buffers empty; RR pointer selects A; age bit cleared.
  - REG_WRITE=0, WRITE_REGISTER=0, WRITE_DATA=0, PENDING=0, BUSY=0.
  - Writes in flight are discarded. Reset mid-operation never produces a partial strobe.
- Handshake:
  - Transfer occurs on a rising edge with X_VALID & X_READY.
  - X_READY = ~full_X | grant_X. A buffer being drained this cycle can accept a new write in the same edge.
  - X_READY depends only on registered state, never on X_VALID.
- Writes to register 0:
  - Accepted normally and occupy the buffer.
  - When granted, the buffer drains but REG_WRITE stays 0.
  - Never set in PENDING.
- Arbitration (combinational over registered buffer state, each cycle):
  - Only one buffer full: grant it.
  - Both full, different addresses: grant the RR-pointer side; pointer flips to the other side on that edge.
  - Both full, same address: grant the older entry (age bit) regardless of pointer; pointer unchanged.
  - Age on simultaneous load: A is older.
  - Age when one loads while the other is already full: the already-full entry is older.
- Output stage (registered):
  - At the edge where a grant is taken, REG_WRITE, WRITE_REGISTER and WRITE_DATA load the granted entry.
  - With no grant, REG_WRITE returns to 0; WRITE_REGISTER/WRITE_DATA hold their last values.
  - Each strobe lasts exactly one cycle.
  - Latency: handshake at edge k -> REG_WRITE high during cycle k+1 to k+2 (earliest; 1 cycle if uncontended).
  - Sustained throughput: 1 write per cycle.
- PENDING:
  - Bit n = (full_A & A_addr==n) | (full_B & B_addr==n) | (REG_WRITE & WRITE_REGISTER==n), for n!=0.
  - Clears in the cycle after the strobe, once the bank has captured the data.
- Back-to-back same-register writes from one requester: serialized in acceptance order; no reordering.

Optional Feature:
- Macro REG_WR_BYPASS_EN.
- Defined, it adds:
  - inputs Q1_ADDR, Q2_ADDR (ADDR_W);
  - outputs Q1_HIT, Q2_HIT (1) and Q1_DATA, Q2_DATA (DATA_W).
- Combinational lookup:
  - HIT=1 when the address is non-zero and matches a pending entry.
  - DATA returns the youngest matching value. Priority: younger buffer, older buffer, output register.
  - With no match, HIT=0 and DATA=0.
- Undefined: these ports do not exist; the hazard unit stalls on PENDING only.

Test Plan:
- Reset then A writes r5=0x0000_00AA -> A_READY=1; REG_WRITE high next cycle with WRITE_REGISTER=5, WRITE_DATA=0xAA; PENDING[5] high for 2 cycles then 0.
- A and B both valid every cycle, A_ADDR=3, B_ADDR=7 -> strobes alternate A,B,A,B… after the first grant goes to A; one write per cycle; READY never low for more than one cycle.
- Same-cycle A r9=0x11 and B r9=0x22 -> strobe order r9=0x11 then r9=0x22; final PENDING[9]=0.
- B writes r0=0xFFFF_FFFF -> buffer drains, REG_WRITE stays 0, PENDING[0]=0 throughout.
- Both buffers full, assert RST_N=0 asynchronously mid-cycle -> REG_WRITE, PENDING and BUSY go 0 immediately; after release no stale strobe appears.
- With REG_WR_BYPASS_EN: A r4=0x10 pending, then B r4=0x20 accepted, Q1_ADDR=4 -> Q1_HIT=1, Q1_DATA=0x20; Q2_ADDR=0 -> Q2_HIT=0.
